// File: rtl/dct_transpose.sv
// dct_transpose -- 8x8 transpose buffer that sits between the row and column
// passes of a 2-D DCT. Rows of row-DCT coefficients are written into one bank
// of a ping-pong pair. The other bank is read out column by column.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : qualifies in_data / in_sob
//   in_sob    : start of block (row 0)
//   in_data   : one row, lane c = column c (W-bit signed lanes)
//   out_valid : qualifies out_data / out_sob / out_eob
//   out_sob   : column 0 of an output block
//   out_eob   : column 7 of an output block
//   out_data  : one column, lane r = row r
//   sync_err  : one-cycle pulse when a partial block is discarded
module dct_transpose #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sob,
  input  logic [7:0][W-1:0]   in_data,
  output logic                out_valid,
  output logic                out_sob,
  output logic                out_eob,
  output logic [7:0][W-1:0]   out_data,
  output logic                sync_err
);

  typedef logic [7:0][W-1:0] row_t;

  // Two banks of eight rows. Contents are deliberately not reset.
  row_t mem [0:1][0:7];

  logic [2:0] wrow_reg;
  logic [2:0] rd_k_reg;
  logic       bank_reg;       // bank currently being written
  logic       rd_active_reg;

  logic [2:0] wr_row;
  logic       blk_done;
  row_t       col_first;
  row_t       col_next;

  // A start-of-block marker always forces row 0. Any partial block in
  // progress is simply overwritten.
  always_comb begin
    wr_row   = in_sob ? 3'd0 : wrow_reg;
    blk_done = in_valid && (wr_row == 3'd7);
  end

  // Column 0 is registered on the same edge that writes row 7. Row 7 is
  // therefore taken straight from the input rather than from the bank.
  // Later columns read the bank that has just filled. After the swap on
  // the row-7 edge, that bank is the one not being written.
  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    if (gi == 7) begin : g_bypass
      assign col_first[gi] = in_data[0];
    end else begin : g_mem
      assign col_first[gi] = mem[bank_reg][gi][0];
    end
    assign col_next[gi] = mem[~bank_reg][gi][rd_k_reg];
  end

  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      mem[bank_reg][wr_row] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrow_reg      <= 3'd0;
      rd_k_reg      <= 3'd0;
      bank_reg      <= 1'b0;
      rd_active_reg <= 1'b0;
      out_valid     <= 1'b0;
      out_sob       <= 1'b0;
      out_eob       <= 1'b0;
      out_data      <= '0;
      sync_err      <= 1'b0;
    end else begin
      sync_err  <= in_valid && in_sob && (wrow_reg != 3'd0);
      out_valid <= 1'b0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;

      if (in_valid) begin
        wrow_reg <= wr_row + 3'd1;
      end

      // A bank needs at least eight write cycles to fill. An earlier read
      // has therefore always issued column 7 by the time blk_done occurs
      // again, so giving blk_done priority never cuts a read short.
      if (blk_done) begin
        bank_reg      <= ~bank_reg;
        rd_active_reg <= 1'b1;
        rd_k_reg      <= 3'd1;
        out_valid     <= 1'b1;
        out_sob       <= 1'b1;
        out_data      <= col_first;
      end else if (rd_active_reg) begin
        out_valid <= 1'b1;
        out_eob   <= (rd_k_reg == 3'd7);
        out_data  <= col_next;
        rd_k_reg  <= rd_k_reg + 3'd1;
        if (rd_k_reg == 3'd7) begin
          rd_active_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose.sv
// Self-checking bench for dct_transpose (W = 16). It has two parts.
// The first part is a cycle-exact vector table for a single block.
// The second part is a set of hand-written sequences. These cover
// back-to-back blocks, input gaps, resync, reset mid-read and signed
// extremes. An observation queue collects the outputs for those sequences.
module tb_dct_transpose;

  localparam int W = 16;
  typedef logic [7:0][W-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_sob;
  row_t in_data;
  logic out_valid;
  logic out_sob;
  logic out_eob;
  row_t out_data;
  logic sync_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int err_cnt = 0;

  typedef struct {
    row_t d;
    logic s;
    logic e;
    int   cyc;
  } obs_t;
  obs_t obs_q[$];

  row_t exp_cols [0:23];

  typedef struct {
    logic v;
    logic sob;
    row_t din;
    logic ev;
    logic esob;
    logic eeob;
    logic chk_dat;
    row_t edat;
  } vec_t;
  vec_t tbl [0:15];

  dct_transpose #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sob(in_sob),
    .in_data(in_data), .out_valid(out_valid), .out_sob(out_sob),
    .out_eob(out_eob), .out_data(out_data), .sync_err(sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output column, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) obs_q.push_back('{d: out_data, s: out_sob, e: out_eob, cyc: cyc});
    if (sync_err) err_cnt++;
  end

  function automatic row_t blk_row(int base, int r);
    row_t x;
    for (int c = 0; c < 8; c++) x[c] = 16'(base + 8 * r + c);
    return x;
  endfunction

  function automatic row_t blk_col(int base, int k);
    row_t x;
    for (int r = 0; r < 8; r++) x[r] = 16'(base + 8 * r + k);
    return x;
  endfunction

  function automatic row_t ext_row(int r);
    row_t x;
    for (int c = 0; c < 8; c++) x[c] = (r % 2 == 0) ? 16'h8000 : 16'h7fff;
    return x;
  endfunction

  function automatic row_t ext_col();
    row_t x;
    for (int r = 0; r < 8; r++) x[r] = (r % 2 == 0) ? 16'h8000 : 16'h7fff;
    return x;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic s, row_t d);
    in_valid = v;
    in_sob   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic send_block(int base, output int t7);
    for (int r = 0; r < 8; r++) drive(1'b1, r == 0, blk_row(base, r));
    t7 = cyc;
  endtask

  // Compare the observation queue against exp_cols[0..n-1]. When t0 >= 0,
  // column i must also have appeared in cycle t0+i.
  task automatic check_q(string nm, int n, int t0);
    chk({nm, "_count"}, 128'(obs_q.size()), 128'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      chk($sformatf("%s_col%0d", nm, i),
          {obs_q[i].d, 1'b0, obs_q[i].s, obs_q[i].e},
          {exp_cols[i], 1'b0, (i % 8 == 0), (i % 8 == 7)});
      if (t0 >= 0)
        chk($sformatf("%s_cyc%0d", nm, i), 128'(obs_q[i].cyc), 128'(t0 + i));
    end
    $display("%s: %0d columns observed, %0d expected", nm, obs_q.size(), n);
  endtask

  initial begin
    int t7;

    rst = 1'b1;
    in_valid = 1'b0;
    in_sob = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_flags", {out_sob, out_eob, sync_err}, 128'(0));
    chk("rst_data", out_data, 128'(0));
    rst = 1'b0;

    // Single contiguous block: cycle-exact table.
    for (int i = 0; i < 16; i++) begin
      tbl[i].v       = (i < 8);
      tbl[i].sob     = (i == 0);
      tbl[i].din     = (i < 8) ? blk_row(0, i) : '0;
      tbl[i].ev      = (i >= 7 && i <= 14);
      tbl[i].esob    = (i == 7);
      tbl[i].eeob    = (i == 14);
      tbl[i].chk_dat = (i >= 7);
      tbl[i].edat    = (i >= 7) ? blk_col(0, (i <= 14) ? i - 7 : 7) : '0;
    end
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].sob, tbl[i].din);
      $display("tbl[%0d] in_valid=%0b out_valid=%0b sob=%0b eob=%0b data=%h",
               i, in_valid, out_valid, out_sob, out_eob, out_data);
      chk($sformatf("tbl%0d_ctl", i), {out_valid, out_sob, out_eob, sync_err},
          {tbl[i].ev, tbl[i].esob, tbl[i].eeob, 1'b0});
      if (tbl[i].chk_dat) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].edat);
    end

    // Three back-to-back blocks.
    obs_q.delete();
    err_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      int t;
      send_block(64 * b, t);
      if (b == 0) t7 = t;
      for (int k = 0; k < 8; k++) exp_cols[8 * b + k] = blk_col(64 * b, k);
    end
    idle(10);
    check_q("b2b", 24, t7);
    chk("b2b_sync_err", 128'(err_cnt), 128'(0));

    // Block with random gaps.
    obs_q.delete();
    for (int r = 0; r < 8; r++) begin
      idle($urandom_range(0, 1));
      drive(1'b1, r == 0, blk_row(0, r));
      if (r < 7) idle($urandom_range(0, 1));
    end
    t7 = cyc;
    drive(1'b0, 1'b0, '0);
    idle(10);
    for (int k = 0; k < 8; k++) exp_cols[k] = blk_col(0, k);
    check_q("gaps", 8, t7);

    // Five rows, then a new start of block: the partial block is dropped.
    obs_q.delete();
    err_cnt = 0;
    for (int r = 0; r < 5; r++) drive(1'b1, r == 0, blk_row(1000, r));
    send_block(200, t7);
    idle(10);
    for (int k = 0; k < 8; k++) exp_cols[k] = blk_col(200, k);
    check_q("resync", 8, t7);
    chk("resync_sync_err", 128'(err_cnt), 128'(1));

    // Reset while column 3 is on the output.
    send_block(300, t7);
    idle(3);
    chk("pre_rst_col3", {out_valid, out_data}, {1'b1, blk_col(300, 3)});
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", out_data, 128'(0));
    rst = 1'b0;
    obs_q.delete();
    idle(10);
    chk("post_rst_quiet", 128'(obs_q.size()), 128'(0));
    // After the reset, the first row is row 0 even without in_sob.
    for (int r = 0; r < 8; r++) drive(1'b1, 1'b0, blk_row(400, r));
    t7 = cyc;
    idle(10);
    for (int k = 0; k < 8; k++) exp_cols[k] = blk_col(400, k);
    check_q("post_rst", 8, t7);

    // Signed extremes.
    obs_q.delete();
    for (int r = 0; r < 8; r++) drive(1'b1, r == 0, ext_row(r));
    t7 = cyc;
    idle(10);
    for (int k = 0; k < 8; k++) exp_cols[k] = ext_col();
    check_q("extremes", 8, t7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_transpose.md
DCT_TRANSPOSE -- requirements
Module: dct_transpose

Interface
REQ-001 Parameter W, default 16, SHALL set the bit width of each coefficient lane, signed.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port in_valid  input  1  SHALL qualify in_data and in_sob in the current cycle.
REQ-005 Port in_sob  input  1  SHALL mark row 0 of an 8x8 block (start of block).
REQ-006 Port in_data  input  8xW signed, packed [7:0][W-1:0]  SHALL carry one row of row-DCT coefficients; lane c is column c.
REQ-007 Port out_valid  output  1  SHALL qualify out_data, out_sob and out_eob.
REQ-008 Port out_sob  output  1  SHALL mark column 0 of an output block.
REQ-009 Port out_eob  output  1  SHALL mark column 7 of an output block.
REQ-010 Port out_data  output  8xW signed, packed [7:0][W-1:0]  SHALL carry one column; lane r is row r.
REQ-011 Port sync_err  output  1  SHALL pulse one cycle when a partial block is discarded.

Function
REQ-012 Storage SHALL be two 8x8xW banks (ping-pong), with one write bank and one read bank at any time.
REQ-013 Write: on in_valid=1, in_data[c] SHALL be stored at wbank[wrow][c], after which wrow SHALL increment by 1, modulo 8.
REQ-014 in_valid=0 cycles (gaps) SHALL be allowed anywhere inside a block; wrow SHALL hold during a gap.
REQ-015 On in_valid=1 with in_sob=1 and wrow!=0, the partial block SHALL be discarded, the row SHALL be written as row 0, wrow SHALL become 1, and sync_err SHALL pulse.
REQ-016 On in_valid=1 with in_sob=0 and wrow=0, the row SHALL be accepted as row 0 (no error).
REQ-017 Capture of row 7 SHALL mark the write bank full, swap bank roles on the same edge, and start a read sequence.
REQ-018 Read: on the 8 consecutive cycles after the row-7 capture edge, out_data[r] SHALL equal rbank[r][k] for k=0..7, with out_valid=1.
REQ-019 Read SHALL NOT stall; there is no backpressure.
REQ-020 out_sob SHALL be 1 only when k=0; out_eob SHALL be 1 only when k=7.
REQ-021 Latency: the first output column SHALL be registered and valid in the cycle after the row-7 write edge; the last column is 8 cycles after it.
REQ-022 A new block's row 0 SHALL be accepted in the cycle right after the row-7 cycle (back-to-back); rows go to the other bank while the read proceeds.
REQ-023 Read and write of different banks in the same cycle SHALL be independent.
REQ-024 Overflow SHALL be impossible by design: a bank needs at least 8 write cycles to fill, and a read takes exactly 8 cycles.
REQ-025 If a block completes on the same edge that the previous read issues column 7, the next read SHALL start on the following cycle with no bubble.
REQ-026 When not reading, out_valid, out_sob and out_eob SHALL be 0, and out_data SHALL hold its last value.
REQ-027 Data SHALL pass unchanged: no arithmetic, rounding or sign change, and the full W bits are preserved.

Reset
REQ-028 While rst=1, on the clock edge: wrow=0, read counter idle, bank select=0, out_valid=0, out_sob=0, out_eob=0, sync_err=0, out_data=0.
REQ-029 A reset mid-block or mid-read SHALL discard the partial input and abort the remaining output columns; bank contents need not be cleared.
REQ-030 The first in_valid after rst deasserts SHALL be treated as row 0.

Verification
REQ-031 Single block, in_data row r lane c = 8r+c, contiguous: out_valid for 8 cycles starting 1 cycle after row 7; column k lane r = 8r+k; out_sob on k=0, out_eob on k=7.
REQ-032 Three back-to-back blocks with no gaps, values offset by 64 per block: 24 contiguous out_valid cycles, every column correct, and no sync_err.
REQ-033 Block with random in_valid gaps (50% duty): output identical to REQ-031, starting 1 cycle after the row-7 capture.
REQ-034 Five rows, then in_sob=1 with a new block: sync_err pulses once, the new block alone is output, and none of the 5 discarded rows appear.
REQ-035 rst=1 asserted during output column 3: out_valid=0 on the next cycle and stays 0 until a new full block is received.
REQ-036 Signed extremes: W=16 lanes of -32768 and 32767 alternating by row: output bit-exact.
